// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic unit family: operation encodings and select width.
package logic_unit_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND   = 3'b000;
    localparam logic [OP_W-1:0] OP_OR    = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR   = 3'b010;
    localparam logic [OP_W-1:0] OP_XNOR  = 3'b011;
    localparam logic [OP_W-1:0] OP_NAND  = 3'b100;
    localparam logic [OP_W-1:0] OP_NOR   = 3'b101;
    localparam logic [OP_W-1:0] OP_ANDN  = 3'b110;
    localparam logic [OP_W-1:0] OP_PASSB = 3'b111;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational N-bit bitwise logic core; shared with later ALU blocks.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]    a,
    input  logic [N-1:0]    b,
    input  logic [OP_W-1:0] op,
    output logic [N-1:0]    y
);

    // Operation decode
    always_comb begin
        y = {N{1'b0}};
        case (op)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_XNOR:  y = ~(a ^ b);
            OP_NAND:  y = ~(a & b);
            OP_NOR:   y = ~(a | b);
            OP_ANDN:  y = a & ~b;
            OP_PASSB: y = b;
            default:  y = {N{1'b0}};
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipelined logic unit with accumulator mode and zero/parity flags.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int N = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    a,
    input  logic [N-1:0]    b,
    input  logic [OP_W-1:0] op,
    input  logic            acc_en,
    input  logic            acc_clr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    result,
    output logic            zero,
    output logic            parity,
    output logic [N-1:0]    acc
);

    function automatic logic odd_parity(input logic [N-1:0] v);
        return ^v;
    endfunction

    logic            s1_valid_q, s1_valid_d;
    logic [N-1:0]    s1_a_q, s1_a_d;
    logic [N-1:0]    s1_b_q, s1_b_d;
    logic [OP_W-1:0] s1_op_q, s1_op_d;
    logic            s1_acc_en_q, s1_acc_en_d;

    logic            out_valid_q, out_valid_d;
    logic [N-1:0]    result_q, result_d;
    logic            zero_q, zero_d;
    logic            parity_q, parity_d;
    logic [N-1:0]    acc_q, acc_d;

    logic            s2_ready_s;
    logic            s2_load_s;
    logic [N-1:0]    core_a_s;
    logic [N-1:0]    core_y_s;

    assign s2_ready_s = !out_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s2_ready_s;
    assign s2_load_s  = s2_ready_s && s1_valid_q;

    // The accumulator is read at compute time so chained acc beats need no bubble.
    assign core_a_s = s1_acc_en_q ? acc_q : s1_a_q;

    logic_unit_core #(.N(N)) u_core (
        .a  (core_a_s),
        .b  (s1_b_q),
        .op (s1_op_q),
        .y  (core_y_s)
    );

    // Next-state for both pipeline stages, flags and accumulator
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_d     = s1_op_q;
        s1_acc_en_d = s1_acc_en_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        parity_d    = parity_q;
        acc_d       = acc_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d      = a;
                s1_b_d      = b;
                s1_op_d     = op;
                s1_acc_en_d = acc_en;
            end else begin
                s1_a_d      = s1_a_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (s2_ready_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = core_y_s;
                zero_d   = (core_y_s == {N{1'b0}});
                parity_d = odd_parity(core_y_s);
            end else begin
                result_d = result_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end

        // A coincident clear beats the write-back of an acc beat.
        if (acc_clr) begin
            acc_d = {N{1'b0}};
        end else if (s2_load_s && s1_acc_en_q) begin
            acc_d = core_y_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= {N{1'b0}};
            s1_b_q      <= {N{1'b0}};
            s1_op_q     <= {OP_W{1'b0}};
            s1_acc_en_q <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= {N{1'b0}};
            zero_q      <= 1'b1;
            parity_q    <= 1'b0;
            acc_q       <= {N{1'b0}};
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            s1_acc_en_q <= s1_acc_en_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            parity_q    <= parity_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign parity    = parity_q;
    assign acc       = acc_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe (N=8).
module tb_logic_unit_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       acc_en;
    logic       acc_clr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       zero;
    logic       parity;
    logic [7:0] acc;

    int checks_cnt;
    int errors_cnt;

    logic [7:0] exp_res [8];

    logic_unit_pipe #(.N(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .parity    (parity),
        .acc       (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] ta, input logic [7:0] tb_v, input logic [2:0] top,
                        input logic tacc);
        in_valid = 1'b1;
        a        = ta;
        b        = tb_v;
        op       = top;
        acc_en   = tacc;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        acc_en   = 1'b0;
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        exp_res[0] = 8'h30; exp_res[1] = 8'hFC; exp_res[2] = 8'hCC; exp_res[3] = 8'h33;
        exp_res[4] = 8'hCF; exp_res[5] = 8'h03; exp_res[6] = 8'hC0; exp_res[7] = 8'h3C;

        rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; op = 3'b000;
        acc_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;

        // 1. reset state
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        check("rst_parity", {31'd0, parity}, 32'd0);
        check("rst_acc", {24'd0, acc}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // 2. all eight ops streamed back to back
        for (int i = 0; i < 8; i++) begin
            beat(8'hF0, 8'h3C, 3'(i), 1'b0);
            check("stream_in_ready", {31'd0, in_ready}, 32'd1);
            tick();
            if (i == 0) begin
                check("stream_lat_first", {31'd0, out_valid}, 32'd0);
            end else begin
                check("stream_valid", {31'd0, out_valid}, 32'd1);
                check($sformatf("stream_res_op%0d", i - 1), {24'd0, result}, {24'd0, exp_res[i-1]});
                check("stream_zero", {31'd0, zero}, 32'd0);
                check("stream_parity", {31'd0, parity}, 32'd0);
            end
        end
        idle();
        tick();
        check("stream_valid_last", {31'd0, out_valid}, 32'd1);
        check("stream_res_op7", {24'd0, result}, {24'd0, exp_res[7]});
        check("stream_zero_last", {31'd0, zero}, 32'd0);
        tick();
        check("stream_drained", {31'd0, out_valid}, 32'd0);

        // 3. full stall for 5 cycles
        out_ready = 1'b0;
        beat(8'h00, 8'h5A, 3'b111, 1'b0);
        tick();
        check("stall_first_ready", {31'd0, in_ready}, 32'd1);
        beat(8'h00, 8'hA5, 3'b111, 1'b0);
        tick();
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        beat(8'h00, 8'h77, 3'b111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
            check("stall_hold_res", {24'd0, result}, 32'h5A);
            check("stall_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        idle();
        out_ready = 1'b1;
        #1;
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("release_b_valid", {31'd0, out_valid}, 32'd1);
        check("release_b_res", {24'd0, result}, 32'hA5);
        tick();
        check("release_no_dup", {31'd0, out_valid}, 32'd0);

        // 4. chained accumulator beats
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        check("acc_cleared", {24'd0, acc}, 32'd0);
        beat(8'h55, 8'h01, 3'b001, 1'b1);
        tick();
        beat(8'h55, 8'h80, 3'b001, 1'b1);
        tick();
        check("acc_chain_r1", {24'd0, result}, 32'h01);
        check("acc_chain_a1", {24'd0, acc}, 32'h01);
        beat(8'h55, 8'hFF, 3'b010, 1'b1);
        tick();
        check("acc_chain_r2", {24'd0, result}, 32'h81);
        idle();
        tick();
        check("acc_chain_r3", {24'd0, result}, 32'h7E);
        check("acc_chain_a3", {24'd0, acc}, 32'h7E);
        tick();

        // 5. clear coinciding with an acc write-back
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        beat(8'h00, 8'hF0, 3'b001, 1'b1);
        tick();
        beat(8'h00, 8'h0F, 3'b001, 1'b1);
        tick();
        check("clr_setup_acc", {24'd0, acc}, 32'hF0);
        idle();
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        check("clr_coinc_res", {24'd0, result}, 32'hFF);
        check("clr_coinc_acc", {24'd0, acc}, 32'h00);
        tick();

        // 6. reset with beats in flight, then recovery
        beat(8'h00, 8'h99, 3'b111, 1'b1);
        tick();
        idle();
        tick();
        check("pre_rst_acc", {24'd0, acc}, 32'h99);
        tick();
        beat(8'hFF, 8'hFF, 3'b000, 1'b1);
        tick();
        beat(8'h12, 8'h34, 3'b001, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            check("post_rst_valid", {31'd0, out_valid}, 32'd0);
            check("post_rst_acc", {24'd0, acc}, 32'd0);
            tick();
        end
        beat(8'h0F, 8'hFF, 3'b010, 1'b0);
        tick();
        check("recov_lat1", {31'd0, out_valid}, 32'd0);
        beat(8'hF0, 8'h0F, 3'b000, 1'b0);
        tick();
        check("recov_valid", {31'd0, out_valid}, 32'd1);
        check("recov_res", {24'd0, result}, 32'hF0);
        beat(8'h00, 8'h01, 3'b111, 1'b0);
        tick();
        check("zero_res", {24'd0, result}, 32'h00);
        check("zero_flag", {31'd0, zero}, 32'd1);
        idle();
        tick();
        check("parity_res", {24'd0, result}, 32'h01);
        check("parity_flag", {31'd0, parity}, 32'd1);
        check("parity_zero", {31'd0, zero}, 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
